// File: rtl/button_step_counter.sv
// Debounced push-button step counter: sync -> debounce -> press pulse -> up/down counter.
// Count changes DEBOUNCE_CYCLES+3 edges after the button is first sampled high; no backpressure.
module button_step_counter #(
  parameter int WIDTH           = 4,
  parameter int MAX_COUNT       = 2**WIDTH-1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit SATURATE        = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             pressed
);

  localparam int               DW       = $clog2(DEBOUNCE_CYCLES+1);
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_COUNT);
  localparam logic [DW:0]      DB_LIMIT = (DW+1)'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic [DW-1:0]    db_cnt_q, db_cnt_d;
  logic [DW:0]      db_inc;
  logic             pressed_q, pressed_d;
  logic             pressed_dly_q;
  logic             pulse_q, pulse_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] load_clamped;

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    db_inc    = {1'b0, db_cnt_q} + (DW+1)'(1);
    pressed_d = pressed_q;
    db_cnt_d  = '0;
    if (sync2_q != pressed_q) begin
      if (db_inc == DB_LIMIT) begin
        pressed_d = ~pressed_q;
      end else begin
        db_cnt_d = db_inc[DW-1:0];
      end
    end
  end

  assign pulse_d      = pressed_q & ~pressed_dly_q;
  assign load_clamped = (load_value > MAX_C) ? MAX_C : load_value;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (pulse_q && enable) begin
      if (up_down) begin
        if (count_q == MAX_C) begin
          tc_d = 1'b1;
          if (!SATURATE) count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
          if (!SATURATE) count_d = MAX_C;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      db_cnt_q      <= '0;
      pressed_q     <= 1'b0;
      pressed_dly_q <= 1'b0;
      pulse_q       <= 1'b0;
      count_q       <= '0;
      tc_q          <= 1'b0;
    end else begin
      sync1_q       <= button;
      sync2_q       <= sync1_q;
      db_cnt_q      <= db_cnt_d;
      pressed_q     <= pressed_d;
      pressed_dly_q <= pressed_q;
      pulse_q       <= pulse_d;
      count_q       <= count_d;
      tc_q          <= tc_d;
    end
  end

  assign counter = count_q;
  assign tc      = tc_q;
  assign pressed = pressed_q;

endmodule
